// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (CPU, DMA) and the memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rvalid;

  logic              dma_req;
  logic              dma_we;
  logic              dma_lock;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic [DATA_W-1:0] dma_rdata;
  logic              dma_rvalid;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rdata, cpu_rvalid,
    input  dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    output dma_gnt, dma_rdata, dma_rvalid,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rdata, cpu_rvalid,
    output dma_req, dma_we, dma_lock, dma_addr, dma_wdata,
    input  dma_gnt, dma_rdata, dma_rvalid,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between a CPU and a DMA/loader, with DMA bus locking.
// Define DMEM_ARB_RR_EN for round-robin contention; otherwise the CPU has fixed priority.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            reset,
  dmem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_LAST = 2'd1,
    DMA_LAST = 2'd2,
    DMA_LOCK = 2'd3
  } state_t;

  state_t state;
  state_t stateNext;
  logic   grantCpu;
  logic   grantDma;
  logic   cpuPreferred;
  logic   tagCpu;
  logic   tagDma;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= stateNext;
  end

  // Grant decision and owner tracking; nothing is granted while reset is held.
  always_comb begin
    grantCpu     = 1'b0;
    grantDma     = 1'b0;
    stateNext    = state;
    cpuPreferred = 1'b1;
`ifdef DMEM_ARB_RR_EN
    cpuPreferred = (state != CPU_LAST);
`endif
    if (!reset) begin
      grantCpu = 1'b0;
      grantDma = 1'b0;
    end else if (state == DMA_LOCK && bus.dma_req && bus.dma_lock) begin
      grantDma = 1'b1;
    end else if (bus.cpu_req && bus.dma_req) begin
      grantCpu = cpuPreferred;
      grantDma = !cpuPreferred;
    end else begin
      grantCpu = bus.cpu_req;
      grantDma = bus.dma_req;
    end

    if (grantDma)               stateNext = bus.dma_lock ? DMA_LOCK : DMA_LAST;
    else if (grantCpu)          stateNext = CPU_LAST;
    else if (state == DMA_LOCK) stateNext = DMA_LAST;
  end

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    if (grantCpu) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end else if (grantDma) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.dma_we;
      bus.mem_addr  = bus.dma_addr;
      bus.mem_wdata = bus.dma_wdata;
    end
  end

  assign bus.cpu_stall = bus.cpu_req & ~grantCpu;
  assign bus.dma_gnt   = grantDma;

  // Read tag follows the synchronous memory's one-cycle latency to the owning port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tagCpu <= 1'b0;
      tagDma <= 1'b0;
    end else begin
      tagCpu <= grantCpu & ~bus.cpu_we;
      tagDma <= grantDma & ~bus.dma_we;
    end
  end

  assign bus.cpu_rvalid = tagCpu;
  assign bus.dma_rvalid = tagDma;
  assign bus.cpu_rdata  = tagCpu ? bus.mem_rdata : {DATA_W{1'b0}};
  assign bus.dma_rdata  = tagDma ? bus.mem_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized self-checking bench for dmem_arbiter against a request-level reference model.
// Honours DMEM_ARB_RR_EN in the model so either build can be checked.
module tb_dmem_arbiter;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checkCount = 0;
  int failCount  = 0;

  logic [31:0] memArr [64];
  logic [31:0] refMem [64];

  int          lastOwner;
  bit          locked;
  bit          expTagCpu;
  bit          expTagDma;
  logic [31:0] expData;

  function automatic logic [31:0] initWord(int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'h0000_5A5A;
  endfunction

  // Synchronous single-port memory: contents reload whenever reset is held.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) memArr[i] = initWord(i);
    end else if (bus.mem_en) begin
      if (bus.mem_we) memArr[bus.mem_addr[7:2]] = bus.mem_wdata;
      else            bus.mem_rdata <= memArr[bus.mem_addr[7:2]];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    lastOwner = 0;
    locked    = 1'b0;
    expTagCpu = 1'b0;
    expTagDma = 1'b0;
    expData   = '0;
    for (int i = 0; i < 64; i++) refMem[i] = initWord(i);
  endtask

  task automatic applyStimulus(input bit cReq, input bit cWe, input logic [31:0] cAddr, input logic [31:0] cWdata,
                               input bit dReq, input bit dWe, input bit dLock,
                               input logic [31:0] dAddr, input logic [31:0] dWdata);
    bit          gCpu;
    bit          gDma;
    bit          eWe;
    logic [31:0] eAddr;
    logic [31:0] eWdata;
    @(negedge clk);
    bus.cpu_req   = cReq;
    bus.cpu_we    = cWe;
    bus.cpu_addr  = cAddr;
    bus.cpu_wdata = cWdata;
    bus.dma_req   = dReq;
    bus.dma_we    = dWe;
    bus.dma_lock  = dLock;
    bus.dma_addr  = dAddr;
    bus.dma_wdata = dWdata;
    #1;
    gCpu = 1'b0;
    gDma = 1'b0;
    if (locked && dReq && dLock) gDma = 1'b1;
    else if (cReq && dReq) begin
`ifdef DMEM_ARB_RR_EN
      if (lastOwner == 1) gDma = 1'b1;
      else                gCpu = 1'b1;
`else
      gCpu = 1'b1;
`endif
    end else begin
      gCpu = cReq;
      gDma = dReq;
    end
    eWe    = gCpu ? cWe    : (gDma ? dWe    : 1'b0);
    eAddr  = gCpu ? cAddr  : (gDma ? dAddr  : 32'd0);
    eWdata = gCpu ? cWdata : (gDma ? dWdata : 32'd0);

    checkOutput("cpu_stall",  32'(bus.cpu_stall),  32'(cReq && !gCpu));
    checkOutput("dma_gnt",    32'(bus.dma_gnt),    32'(gDma));
    checkOutput("mem_en",     32'(bus.mem_en),     32'(gCpu || gDma));
    checkOutput("mem_we",     32'(bus.mem_we),     32'(eWe));
    checkOutput("mem_addr",   bus.mem_addr,        eAddr);
    checkOutput("mem_wdata",  bus.mem_wdata,       eWdata);
    checkOutput("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(expTagCpu));
    checkOutput("dma_rvalid", 32'(bus.dma_rvalid), 32'(expTagDma));
    checkOutput("cpu_rdata",  bus.cpu_rdata,       expTagCpu ? expData : 32'd0);
    checkOutput("dma_rdata",  bus.dma_rdata,       expTagDma ? expData : 32'd0);

    @(posedge clk);
    expTagCpu = gCpu && !cWe;
    expTagDma = gDma && !dWe;
    if (gCpu || gDma) begin
      if (eWe) refMem[eAddr[7:2]] = eWdata;
      else     expData = refMem[eAddr[7:2]];
    end
    if (gDma) begin
      lastOwner = 2;
      locked    = dLock;
    end else begin
      if (gCpu) lastOwner = 1;
      locked = 1'b0;
    end
    #1;
  endtask

  task automatic holdReset();
    @(negedge clk);
    reset       = 1'b0;
    bus.cpu_req = 1'b1;
    bus.dma_req = 1'b1;
    bus.cpu_we  = 1'b0;
    bus.dma_we  = 1'b1;
    bus.dma_lock = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_en",     32'(bus.mem_en),     32'd0);
    checkOutput("rst_mem_we",     32'(bus.mem_we),     32'd0);
    checkOutput("rst_dma_gnt",    32'(bus.dma_gnt),    32'd0);
    checkOutput("rst_cpu_stall",  32'(bus.cpu_stall),  32'd1);
    checkOutput("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    checkOutput("rst_dma_rvalid", 32'(bus.dma_rvalid), 32'd0);
    checkOutput("rst_cpu_rdata",  bus.cpu_rdata,       32'd0);
    modelReset();
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    reset       = 1'b1;
  endtask

  function automatic logic [31:0] randAddr();
    return 32'($urandom_range(0, 63)) << 2;
  endfunction

  initial begin
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.dma_req = 1'b0; bus.dma_we = 1'b0; bus.dma_lock = 1'b0;
    bus.dma_addr = '0; bus.dma_wdata = '0;

    holdReset();

    applyStimulus(1, 1, 32'd100, 32'd25, 0, 0, 0, 32'd0, 32'd0);
    applyStimulus(1, 0, 32'd100, 32'd0,  0, 0, 0, 32'd0, 32'd0);

    // Both ports reading continuously
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 0, 32'd8 + 32'(i) * 4, 32'd0, 1, 0, 0, 32'd64 + 32'(i) * 4, 32'd0);

    // Locked DMA burst, then release the lock with the CPU still waiting
    applyStimulus(0, 0, 32'd0,  32'd0, 1, 1, 1, 32'd96,  32'h1111);
    applyStimulus(1, 0, 32'd40, 32'd0, 1, 1, 1, 32'd100, 32'h2222);
    applyStimulus(1, 0, 32'd40, 32'd0, 1, 1, 1, 32'd104, 32'h3333);
    applyStimulus(1, 0, 32'd40, 32'd0, 1, 0, 0, 32'd96,  32'd0);
    applyStimulus(0, 0, 32'd0,  32'd0, 1, 0, 0, 32'd104, 32'd0);
    applyStimulus(0, 0, 32'd0,  32'd0, 0, 0, 0, 32'd0,   32'd0);

    // Reset lands while a CPU read is in flight
    applyStimulus(1, 0, 32'd100, 32'd0, 0, 0, 0, 32'd0, 32'd0);
    reset       = 1'b0;
    bus.cpu_req = 1'b0;
    bus.dma_req = 1'b0;
    modelReset();
    @(negedge clk);
    checkOutput("midrst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 32'd0, 32'd0, 0, 0, 0, 32'd0, 32'd0);
    applyStimulus(1, 0, 32'd100, 32'd0, 0, 0, 0, 32'd0, 32'd0);
    applyStimulus(0, 0, 32'd0,   32'd0, 0, 0, 0, 32'd0, 32'd0);

    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, randAddr(), $urandom,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                    randAddr(), $urandom);
    end

    holdReset();
    applyStimulus(1, 0, 32'd100, 32'd0, 1, 0, 0, 32'd4, 32'd0);
    applyStimulus(0, 0, 32'd0,   32'd0, 1, 0, 0, 32'd4, 32'd0);
    applyStimulus(0, 0, 32'd0,   32'd0, 0, 0, 0, 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
